nvram_ioctl_bridge: RTL and testbench
=====================================

NVRAM_IOCTL_BRIDGE -- requirements
Module: nvram_ioctl_bridge

Interface
REQ-001 Parameter CMOS_BASE, 23'h1CC00, SDRAM byte address of the 1 KB CMOS image.
REQ-002 Parameter CMOS_ROM_PAGE, 13'h034, value of ioctl_addr[22:10] that redirects index-0 bytes (0xD000-0xD3FF) to CMOS.
REQ-003 Parameter NVRAM_INDEX, 8'hFF, ioctl_index whose whole payload maps to CMOS.
REQ-004 clk_sys  in  1  single clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ioctl_download  in  1  download window active.
REQ-007 ioctl_upload  in  1  upload window active (NVRAM save).
REQ-008 ioctl_index  in  8  payload index.
REQ-009 ioctl_wr  in  1  download byte strobe; a write is its rising edge.
REQ-010 ioctl_addr  in  25  byte address.
REQ-011 ioctl_dout  in  8  download byte.
REQ-012 ioctl_din  out  8  upload byte for ioctl_addr.
REQ-013 ioctl_din_valid  out  1  ioctl_din matches the current ioctl_addr[9:0].
REQ-014 port_req  out  1  SDRAM toggle request.
REQ-015 port_ack  in  1  SDRAM toggle acknowledge; the request is complete when port_ack == port_req.
REQ-016 port_a  out  23  SDRAM byte address.
REQ-017 port_we  out  1  1 = write, 0 = read; held stable while a request is outstanding.
REQ-018 port_d  out  16  write data.
REQ-019 port_q  in  16  read data; valid in the cycle port_ack matches.
REQ-020 pause  out  1  high while ioctl_upload is high or the FSM is not IDLE.
REQ-021 overrun  out  1  sticky; a download byte was dropped.

Function
REQ-022 FSM states: IDLE, WR_WAIT, RD_WAIT; one request is outstanding at most.
REQ-023 Download address map: (index 0 and ioctl_addr[22:10] == CMOS_ROM_PAGE) or index == NVRAM_INDEX gives CMOS_BASE | ioctl_addr[9:0]; otherwise ioctl_addr[22:0].
REQ-024 Download data: port_d = {dout[7:4], dout[7:4], dout[3:0], dout[3:0]}; port_we = 1.
REQ-025 Each ioctl_wr rising edge during ioctl_download captures the mapped address and data into a 1-entry holding register.
REQ-026 IDLE with the holding register full: load port_a and port_d, toggle port_req, free the holding register, go to WR_WAIT.
REQ-027 WR_WAIT: stay until port_ack == port_req, then go to IDLE; a queued byte is issued the following cycle.
REQ-028 Byte arriving while the holding register is full: the byte is dropped and overrun is set until reset.
REQ-029 Same-cycle capture and issue is allowed; the holding register never loses a byte in that case.
REQ-030 Upload read trigger: rising edge of ioctl_upload, or a change in ioctl_addr[9:0] while ioctl_upload is high.
REQ-031 Each read trigger clears ioctl_din_valid and sets a pending-read flag.
REQ-032 IDLE with a pending read and the holding register empty: port_a = CMOS_BASE | ioctl_addr[9:0], port_we = 0, toggle port_req, go to RD_WAIT.
REQ-033 RD_WAIT: when port_ack == port_req, ioctl_din <= {port_q[11:8], port_q[3:0]}.
REQ-034 RD_WAIT completion: ioctl_din_valid <= 1 only if ioctl_addr[9:0] is unchanged since issue; otherwise the read is reissued. Then go to IDLE.
REQ-035 Address wrap: only ioctl_addr[9:0] is used for CMOS, so upload address 1024 reads CMOS byte 0.
REQ-036 ioctl_download and ioctl_upload both high: download takes priority and upload triggers are ignored.
REQ-037 Fall of ioctl_upload clears the pending read and ioctl_din_valid; an outstanding read still completes its handshake.
REQ-038 Upload latency: request issued 1 cycle after the trigger; ioctl_din_valid asserts 1 cycle after the ack match.

Reset
REQ-039 On reset: state IDLE; holding register and pending flag cleared; overrun 0; ioctl_din 8'h00; ioctl_din_valid 0.
REQ-040 On reset: port_a 0, port_d 0, port_we 0.
REQ-041 On reset: port_req <= port_ack, so no request is issued and the handshake is resynchronised.
REQ-042 Reset mid-transaction abandons the transaction; no further toggles occur until a new trigger.

Verification
REQ-043 Index 0, addr 0xD005, dout 0xA5, ack 3 cycles later -> port_a 0x1CC05, port_d 0xAA55, port_we 1, one req toggle, IDLE after ack.
REQ-044 Index 0, addr 0x01234, dout 0x3C -> port_a 0x01234, port_d 0x33CC.
REQ-045 Three wr strobes 1 cycle apart, ack withheld 10 cycles -> bytes 1-2 written in order, byte 3 dropped, overrun = 1.
REQ-046 Upload, addr 0x002, port_q 0x0B07 -> ioctl_din 0xB7, valid 1; addr changes to 0x003 -> valid 0 the next cycle, new read at 0x1CC03.
REQ-047 Addr changes during RD_WAIT -> valid stays 0, read reissued, final data is for the new address.
REQ-048 Reset while in WR_WAIT with port_ack = 0, port_req = 1 -> port_req = 0, state IDLE, no toggle; simultaneous download and upload -> only writes issued.

Source files
------------

// File: rtl/nvram_ioctl_bridge.sv
// Bridges the ioctl download/upload byte stream onto a toggle-handshake SDRAM port,
// folding ROM-page and NVRAM-index bytes into the 1 KB CMOS image.
module nvram_ioctl_bridge #(
  parameter logic [22:0] CMOS_BASE     = 23'h1CC00,
  parameter logic [12:0] CMOS_ROM_PAGE = 13'h034,
  parameter logic [7:0]  NVRAM_INDEX   = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_din_valid,
  output logic        port_req,
  input  logic        port_ack,
  output logic [22:0] port_a,
  output logic        port_we,
  output logic [15:0] port_d,
  input  logic [15:0] port_q,
  output logic        pause,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_e;

  state_e      state_q, state_d;
  logic        wr_q, upl_q;
  logic [9:0]  addr_lo_q;
  logic        hold_vld_q, hold_vld_d;
  logic [22:0] hold_a_q, hold_a_d;
  logic [15:0] hold_d_q, hold_d_d;
  logic        rd_pend_q, rd_pend_d;
  logic [9:0]  rd_addr_q, rd_addr_d;
  logic        port_req_q, port_req_d;
  logic [22:0] port_a_q, port_a_d;
  logic        port_we_q, port_we_d;
  logic [15:0] port_d_q, port_d_d;
  logic [7:0]  din_q, din_d;
  logic        din_vld_q, din_vld_d;
  logic        overrun_q, overrun_d;
  logic        issue_wr, issue_rd;

  logic [9:0]  addr_lo;
  logic        wr_rise, rd_trig, upl_fall, ack_match, cmos_hit;
  logic [22:0] dl_addr;
  logic [15:0] dl_data;
  logic        unused_bits;

  assign addr_lo   = ioctl_addr[9:0];
  assign wr_rise   = ioctl_download & ioctl_wr & ~wr_q;
  // Download owns the bridge while active, so upload triggers are ignored then.
  assign rd_trig   = ioctl_upload & ~ioctl_download & (~upl_q | (addr_lo != addr_lo_q));
  assign upl_fall  = ~ioctl_upload & upl_q;
  assign ack_match = (port_ack == port_req_q);
  assign cmos_hit  = ((ioctl_index == 8'h00) && (ioctl_addr[22:10] == CMOS_ROM_PAGE)) ||
                     (ioctl_index == NVRAM_INDEX);
  assign dl_addr   = cmos_hit ? (CMOS_BASE | {13'd0, addr_lo}) : ioctl_addr[22:0];
  assign dl_data   = {ioctl_dout[7:4], ioctl_dout[7:4], ioctl_dout[3:0], ioctl_dout[3:0]};
  assign unused_bits = ^{port_q[15:12], port_q[7:4], ioctl_addr[24:23]};

  always_comb begin
    state_d    = state_q;
    hold_vld_d = hold_vld_q;
    hold_a_d   = hold_a_q;
    hold_d_d   = hold_d_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    port_req_d = port_req_q;
    port_a_d   = port_a_q;
    port_we_d  = port_we_q;
    port_d_d   = port_d_q;
    din_d      = din_q;
    din_vld_d  = din_vld_q;
    overrun_d  = overrun_q;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_vld_q) begin
          port_a_d   = hold_a_q;
          port_d_d   = hold_d_q;
          port_we_d  = 1'b1;
          port_req_d = ~port_req_q;
          hold_vld_d = 1'b0;
          issue_wr   = 1'b1;
          state_d    = WR_WAIT;
        end else if (rd_pend_q) begin
          port_a_d   = CMOS_BASE | {13'd0, addr_lo};
          port_we_d  = 1'b0;
          port_req_d = ~port_req_q;
          rd_addr_d  = addr_lo;
          rd_pend_d  = 1'b0;
          issue_rd   = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (ack_match) state_d = IDLE;
      end
      RD_WAIT: begin
        if (ack_match) begin
          din_d = {port_q[11:8], port_q[3:0]};
          // Data is only trusted if the host address did not move under the read.
          if ((addr_lo == rd_addr_q) && ioctl_upload && !rd_pend_q && !rd_trig)
            din_vld_d = 1'b1;
          else if (ioctl_upload)
            rd_pend_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte may land in the same cycle the previous one leaves the holding register.
    if (wr_rise) begin
      if (hold_vld_q && !issue_wr) begin
        overrun_d = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_a_d   = dl_addr;
        hold_d_d   = dl_data;
      end
    end

    if (rd_trig) begin
      din_vld_d = 1'b0;
      if (!issue_rd) rd_pend_d = 1'b1;
    end

    if (upl_fall) begin
      rd_pend_d = 1'b0;
      din_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= ioctl_wr;
      upl_q      <= ioctl_upload;
      addr_lo_q  <= addr_lo;
      hold_vld_q <= 1'b0;
      hold_a_q   <= '0;
      hold_d_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      port_req_q <= port_ack;
      port_a_q   <= '0;
      port_we_q  <= 1'b0;
      port_d_q   <= '0;
      din_q      <= '0;
      din_vld_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= ioctl_wr;
      upl_q      <= ioctl_upload;
      addr_lo_q  <= addr_lo;
      hold_vld_q <= hold_vld_d;
      hold_a_q   <= hold_a_d;
      hold_d_q   <= hold_d_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      port_req_q <= port_req_d;
      port_a_q   <= port_a_d;
      port_we_q  <= port_we_d;
      port_d_q   <= port_d_d;
      din_q      <= din_d;
      din_vld_q  <= din_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ioctl_din       = din_q;
  assign ioctl_din_valid = din_vld_q;
  assign port_req        = port_req_q;
  assign port_a          = port_a_q;
  assign port_we         = port_we_q;
  assign port_d          = port_d_q;
  assign overrun         = overrun_q;
  assign pause           = ioctl_upload | (state_q != IDLE);

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Bench for nvram_ioctl_bridge: toggle-handshake SDRAM responder plus a byte-level
// CMOS image model that download writes update and upload reads are checked against.
module tb_nvram_ioctl_bridge;
  localparam logic [22:0] CMOS_BASE     = 23'h1CC00;
  localparam logic [12:0] CMOS_ROM_PAGE = 13'h034;
  localparam logic [7:0]  NVRAM_INDEX   = 8'hFF;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'h00, ioctl_dout = 8'h00;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_din_valid;
  logic        port_req, port_we, pause, overrun;
  logic        port_ack = 1'b0;
  logic [22:0] port_a;
  logic [15:0] port_d;
  logic [15:0] port_q = 16'h0000;

  int checks = 0, passed = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_ioctl_bridge #(.CMOS_BASE(CMOS_BASE), .CMOS_ROM_PAGE(CMOS_ROM_PAGE),
                       .NVRAM_INDEX(NVRAM_INDEX)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_din_valid(ioctl_din_valid), .port_req(port_req), .port_ack(port_ack),
    .port_a(port_a), .port_we(port_we), .port_d(port_d), .port_q(port_q),
    .pause(pause), .overrun(overrun));

  // SDRAM model and request log
  typedef struct { logic we; logic [22:0] a; logic [15:0] d; } txn_t;
  txn_t log_q[$];
  logic [15:0] sdram [int unsigned];
  logic [7:0]  cmos_ref [1024];
  int   ack_delay = 2;
  bit   hold_ack = 1'b0;
  bit   resp_en = 1'b0;
  int   cnt = 0;
  logic last_req = 1'b0;

  function automatic logic [15:0] dflt(input logic [22:0] a);
    return {a[7:0] ^ 8'h96, a[7:0] + 8'h3B};
  endfunction

  function automatic logic [15:0] rd_word(input logic [22:0] a);
    if (sdram.exists(int'(a))) return sdram[int'(a)];
    return dflt(a);
  endfunction

  function automatic logic [22:0] map_addr(input logic [7:0] idx, input logic [24:0] a);
    if ((idx == 8'h00 && a[22:10] == CMOS_ROM_PAGE) || idx == NVRAM_INDEX)
      return CMOS_BASE + 23'(a[9:0]);
    return a[22:0];
  endfunction

  function automatic logic [15:0] exp_word(input logic [7:0] b);
    return 16'(b[7:4]) * 16'h1100 + 16'(b[3:0]) * 16'h0011;
  endfunction

  always @(negedge clk_sys) begin
    if (resp_en) begin
      if (port_req !== last_req) begin
        last_req = port_req;
        if (port_req !== port_ack) log_q.push_back('{port_we, port_a, port_d});
      end
      if (port_req === port_ack) cnt = 0;
      else if (!hold_ack) begin
        cnt++;
        if (cnt >= ack_delay) begin
          if (port_we) sdram[int'(port_a)] = port_d;
          port_q   = rd_word(port_a);
          port_ack = port_req;
          cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] b);
    logic [22:0] ma;
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = b; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    ma = map_addr(idx, a);
    if (ma >= CMOS_BASE && ma < CMOS_BASE + 23'd1024) cmos_ref[int'(ma - CMOS_BASE)] = b;
  endtask

  task automatic wait_quiet(output bit ok);
    int run = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (port_req === port_ack) run++; else run = 0;
      if (run >= 3) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ioctl_din_valid === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    last_req = port_req; resp_en = 1'b1;
    reset = 1'b0; tick();
    checks++; if (port_req !== port_ack) $display("FAIL rst_req: got %b want %b", port_req, port_ack); else passed++;
    checks++; if (port_a !== 23'h0) $display("FAIL rst_port_a: got %h want 0", port_a); else passed++;
    checks++; if (port_d !== 16'h0) $display("FAIL rst_port_d: got %h want 0", port_d); else passed++;
    checks++; if (port_we !== 1'b0) $display("FAIL rst_port_we: got %b want 0", port_we); else passed++;
    checks++; if (ioctl_din !== 8'h00) $display("FAIL rst_din: got %h want 00", ioctl_din); else passed++;
    checks++; if (ioctl_din_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ioctl_din_valid); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun); else passed++;
    checks++; if (pause !== 1'b0) $display("FAIL rst_pause: got %b want 0", pause); else passed++;
  endtask

  task automatic test_write_cmos();
    bit ok;
    log_q.delete(); ack_delay = 3; ioctl_download = 1'b1;
    strobe(8'h00, 25'h0D005, 8'hA5);
    checks++; if (port_a !== 23'h1CC05) $display("FAIL wr_cmos_a: got %h want 1cc05", port_a); else passed++;
    checks++; if (port_d !== 16'hAA55) $display("FAIL wr_cmos_d: got %h want aa55", port_d); else passed++;
    checks++; if (port_we !== 1'b1) $display("FAIL wr_cmos_we: got %b want 1", port_we); else passed++;
    checks++; if (pause !== 1'b1) $display("FAIL wr_cmos_pause_busy: got %b want 1", pause); else passed++;
    wait_quiet(ok);
    checks++; if (!ok) $display("FAIL wr_cmos_timeout: got busy want idle"); else passed++;
    checks++; if (log_q.size() !== 1) $display("FAIL wr_cmos_toggles: got %0d want 1", log_q.size()); else passed++;
    checks++; if (pause !== 1'b0) $display("FAIL wr_cmos_pause_idle: got %b want 0", pause); else passed++;
  endtask

  task automatic test_write_plain();
    bit ok;
    log_q.delete(); ack_delay = 1;
    strobe(8'h00, 25'h01234, 8'h3C);
    wait_quiet(ok);
    checks++; if (!ok || log_q.size() != 1) $display("FAIL wr_plain_count: got %0d want 1", log_q.size()); else passed++;
    if (log_q.size() > 0) begin
      checks++; if (log_q[0].a !== 23'h01234) $display("FAIL wr_plain_a: got %h want 01234", log_q[0].a); else passed++;
      checks++; if (log_q[0].d !== 16'h33CC) $display("FAIL wr_plain_d: got %h want 33cc", log_q[0].d); else passed++;
    end
  endtask

  task automatic test_overrun();
    bit ok;
    log_q.delete(); ack_delay = 10;
    strobe(8'h00, 25'h00100, 8'h11);
    strobe(8'h00, 25'h00101, 8'h22);
    strobe(8'h00, 25'h00102, 8'h33);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
    wait_quiet(ok);
    checks++; if (!ok || log_q.size() != 2) $display("FAIL ovr_count: got %0d want 2", log_q.size()); else passed++;
    if (log_q.size() == 2) begin
      checks++; if (log_q[0].a !== 23'h00100 || log_q[0].d !== 16'h1111)
        $display("FAIL ovr_first: got %h/%h want 00100/1111", log_q[0].a, log_q[0].d); else passed++;
      checks++; if (log_q[1].a !== 23'h00101 || log_q[1].d !== 16'h2222)
        $display("FAIL ovr_second: got %h/%h want 00101/2222", log_q[1].a, log_q[1].d); else passed++;
    end
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
    do_reset();
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_upload();
    bit ok;
    ioctl_download = 1'b0; ack_delay = 2;
    sdram[int'(23'h1CC02)] = 16'h0B07;
    ioctl_addr = 25'h002; ioctl_upload = 1'b1;
    tick();
    checks++; if (ioctl_din_valid !== 1'b0) $display("FAIL ul_valid_early: got %b want 0", ioctl_din_valid); else passed++;
    tick();
    checks++; if (port_a !== 23'h1CC02 || port_we !== 1'b0 || port_req === port_ack)
      $display("FAIL ul_issue: got a=%h we=%b want a=1cc02 we=0 pending", port_a, port_we); else passed++;
    wait_valid(ok);
    checks++; if (!ok || ioctl_din !== 8'hB7) $display("FAIL ul_data: got %h want b7", ioctl_din); else passed++;
    ioctl_addr = 25'h003;
    tick();
    checks++; if (ioctl_din_valid !== 1'b0) $display("FAIL ul_valid_drop: got %b want 0", ioctl_din_valid); else passed++;
    tick();
    checks++; if (port_a !== 23'h1CC03 || port_we !== 1'b0)
      $display("FAIL ul_reissue: got a=%h we=%b want 1cc03/0", port_a, port_we); else passed++;
    wait_valid(ok);
    checks++; if (!ok || ioctl_din !== cmos_ref[3]) $display("FAIL ul_data3: got %h want %h", ioctl_din, cmos_ref[3]); else passed++;
  endtask

  task automatic test_addr_change();
    bit ok;
    ack_delay = 6;
    ioctl_addr = 25'h010;
    tick(); tick();
    ioctl_addr = 25'h011;
    tick(); tick(); tick();
    checks++; if (ioctl_din_valid !== 1'b0) $display("FAIL mv_valid_low: got %b want 0", ioctl_din_valid); else passed++;
    wait_valid(ok);
    checks++; if (!ok || ioctl_din !== cmos_ref[17]) $display("FAIL mv_data: got %h want %h", ioctl_din, cmos_ref[17]); else passed++;
    checks++; if (log_q.size() < 2 || log_q[$].a !== 23'h1CC11 || log_q[$-1].a !== 23'h1CC10)
      $display("FAIL mv_reissue: got last a=%h want 1cc11 after 1cc10", log_q[$].a); else passed++;
    ioctl_upload = 1'b0;
    tick();
    checks++; if (ioctl_din_valid !== 1'b0) $display("FAIL ul_fall_valid: got %b want 0", ioctl_din_valid); else passed++;
    wait_quiet(ok);
    checks++; if (!ok || pause !== 1'b0) $display("FAIL ul_fall_pause: got %b want 0", pause); else passed++;
  endtask

  task automatic test_reset_midwrite();
    int n;
    hold_ack = 1'b1; ioctl_download = 1'b1;
    strobe(8'h00, 25'h00200, 8'h44);
    checks++; if (port_req === port_ack) $display("FAIL mid_pending: got req=%b want != ack %b", port_req, port_ack); else passed++;
    do_reset();
    checks++; if (port_req !== port_ack) $display("FAIL mid_resync: got req=%b want %b", port_req, port_ack); else passed++;
    checks++; if (pause !== 1'b0) $display("FAIL mid_idle: got pause=%b want 0", pause); else passed++;
    n = log_q.size(); hold_ack = 1'b0;
    repeat (5) tick();
    checks++; if (log_q.size() != n) $display("FAIL mid_no_toggle: got %0d want %0d", log_q.size(), n); else passed++;
  endtask

  task automatic test_dl_ul_both();
    bit ok;
    int n = log_q.size();
    bit any_rd = 1'b0;
    ack_delay = 2; ioctl_download = 1'b1; ioctl_upload = 1'b1;
    strobe(NVRAM_INDEX, 25'h00007, 8'h5E);
    ioctl_addr = 25'h009; tick(); ioctl_addr = 25'h00A; tick();
    wait_quiet(ok);
    for (int i = n; i < log_q.size(); i++) if (log_q[i].we !== 1'b1) any_rd = 1'b1;
    checks++; if (!ok || any_rd || log_q.size() != n + 1)
      $display("FAIL both_writes_only: got %0d txns rd=%b want 1 write", log_q.size() - n, any_rd); else passed++;
    if (log_q.size() == n + 1) begin
      checks++; if (log_q[n].a !== 23'h1CC07 || log_q[n].d !== 16'h55EE)
        $display("FAIL both_write: got %h/%h want 1cc07/55ee", log_q[n].a, log_q[n].d); else passed++;
    end
    ioctl_upload = 1'b0; ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] idx, b;
    logic [24:0] a;
    ioctl_download = 1'b1;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0: begin idx = NVRAM_INDEX; a = 25'($urandom); end
        1: begin idx = 8'h00; a = {2'($urandom), CMOS_ROM_PAGE, 10'($urandom)}; end
        default: begin idx = 8'($urandom_range(0, 254)); a = {2'($urandom), 13'($urandom_range(0, 51)), 10'($urandom)}; end
      endcase
      b = 8'($urandom);
      ack_delay = $urandom_range(1, 4);
      strobe(idx, a, b);
      wait_quiet(ok);
      checks++; if (!ok || log_q[$].we !== 1'b1 || log_q[$].a !== map_addr(idx, a) || log_q[$].d !== exp_word(b))
        $display("FAIL rnd_write%0d: got %b/%h/%h want 1/%h/%h", i, log_q[$].we, log_q[$].a, log_q[$].d,
                 map_addr(idx, a), exp_word(b)); else passed++;
    end
    ioctl_download = 1'b0; ioctl_upload = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = (i == 0) ? 25'd1029 : 25'($urandom);
      ack_delay = $urandom_range(1, 4);
      ioctl_addr = a;
      tick();
      wait_valid(ok);
      checks++; if (!ok || ioctl_din !== cmos_ref[int'(a[9:0])])
        $display("FAIL rnd_read%0d: got %h want %h at %h", i, ioctl_din, cmos_ref[int'(a[9:0])], a); else passed++;
    end
    ioctl_upload = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = dflt(CMOS_BASE + 23'(i));
      cmos_ref[i] = {w[11:8], w[3:0]};
    end
    test_reset();
    test_write_cmos();
    test_write_plain();
    test_overrun();
    test_upload();
    test_addr_change();
    test_reset_midwrite();
    test_dl_ul_both();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
